// File: rtl/palette_lut.sv
// Multi-bank run-time programmable colour palette with a two-stage lookup/fade pipeline.
// Index + bank in, faded RGB444 out two cycles later; illegal lookups return DEBUG_COLOR.
module palette_lut #(
  parameter int          IDX_W       = 4,
  parameter int          NUM_ENTRIES = 16,
  parameter int          NUM_BANKS   = 2,
  parameter int          BANK_W      = 1,
  parameter logic [11:0] DEBUG_COLOR = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [BANK_W-1:0] in_bank,
  input  logic [3:0]        fade_level,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [11:0]       wr_data,
  output logic              out_valid,
  output logic [11:0]       rgb_out
);

  localparam logic [11:0] START_PAL [8] = '{12'hBEB, 12'hDD0, 12'hFFF, 12'hC54,
                                            12'h7BA, 12'h6CB, 12'h435, 12'hAC5};

  logic [11:0] pal_r [NUM_BANKS][NUM_ENTRIES];
  logic        s1_valid_r;
  logic [11:0] s1_color_r;
  logic [3:0]  s1_fade_r;
  logic [11:0] lut_s;
  logic [11:0] color_s;
  logic        wr_ok_s;
  logic        collide_s;

  function automatic logic [11:0] reset_color(input int b, input int e);
    reset_color = (b == 0 && e < 8) ? START_PAL[e[2:0]] : DEBUG_COLOR;
  endfunction

  function automatic logic [3:0] fade4(input logic [3:0] c, input logic [3:0] f);
    fade4 = (c > f) ? (c - f) : 4'h0;
  endfunction

  function automatic logic [11:0] fade12(input logic [11:0] c, input logic [3:0] f);
    fade12 = {fade4(c[11:8], f), fade4(c[7:4], f), fade4(c[3:0], f)};
  endfunction

  // Palette storage: restored to the start-screen palette on reset, written in place otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < NUM_ENTRIES; e++)
          pal_r[b][e] <= reset_color(b, e);
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int e = 0; e < NUM_ENTRIES; e++)
          if (wr_en && 32'(wr_bank) == b && 32'(wr_index) == e)
            pal_r[b][e] <= wr_data;
    end
  end

  // Lookup mux; an out-of-range bank or index matches no entry and falls through to DEBUG_COLOR
  always_comb begin
    lut_s = DEBUG_COLOR;
    for (int b = 0; b < NUM_BANKS; b++)
      for (int e = 0; e < NUM_ENTRIES; e++)
        lut_s = (32'(in_bank) == b && 32'(in_index) == e) ? pal_r[b][e] : lut_s;
    wr_ok_s   = (32'(wr_bank) < NUM_BANKS) && (32'(wr_index) < NUM_ENTRIES);
    collide_s = wr_en && wr_ok_s && (wr_bank == in_bank) && (wr_index == in_index);
    color_s   = collide_s ? wr_data : lut_s;
  end

  // Stage 1 captures colour and fade; stage 2 applies the saturating fade
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_color_r <= 12'h000;
      s1_fade_r  <= 4'h0;
      out_valid  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      s1_valid_r <= in_valid;
      s1_color_r <= color_s;
      s1_fade_r  <= fade_level;
      out_valid  <= s1_valid_r;
      rgb_out    <= fade12(s1_color_r, s1_fade_r);
    end
  end

endmodule
